// File: rtl/sound_pulse_meter_pkg.sv
// Shared constants and the FSM state type for the sound pulse meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sound_pulse_meter_pkg;

    localparam int CLK_HZ      = 50_000_000;
    // 1 kHz nominal tone at CLK_HZ.
    localparam int DEF_NOM_PER = CLK_HZ / 1000;
    localparam int DEF_CNT_W   = 18;
    localparam int DEF_MAX_CNT = 262143;
    localparam int DEF_TOL     = 500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sound_pulse_meter_sync_edge_detect.sv
// Purpose: 2-FF synchronizer plus edge register for an async 1-bit input.
// Latency: rise/fall assert 3 clk_50M edges after the pin transition.
// Backpressure: none; free-running, one-cycle edge pulses.
//  clk_50M in  : clock
//  reset   in  : synchronous active-high, clears the edge pulses
//  din     in  : asynchronous input
//  level   out : synchronized level (aligned with rise/fall)
//  rise    out : one-cycle pulse on a 0->1 of the synchronized level
//  fall    out : one-cycle pulse on a 1->0 of the synchronized level
module sync_edge_detect (
    input  logic clk_50M,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_ff1;
    logic sync_ff2;
    logic level_q;

    // The synchronizer and level history keep tracking through reset so the
    // first edge after reset release reflects a real pin transition rather
    // than the pin level differing from a reset value.
    always_ff @(posedge clk_50M) begin
        sync_ff1 <= din;
        sync_ff2 <= sync_ff1;
        level_q  <= sync_ff2;
        if (reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= sync_ff2 & ~level_q;
            fall <= ~sync_ff2 & level_q;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/sound_pulse_meter.sv
// Purpose: measures period and high width of a 1-bit sound pulse train, flags tone match/silence.
// Latency: result strobes 4 clk_50M edges after the pin rise that closes a period.
// Backpressure: none; meas_valid is a one-cycle strobe that must be consumed when seen.
//  clk_50M    in  : 50 MHz clock
//  reset      in  : synchronous active-high reset
//  pulse_in   in  : asynchronous pulse train
//  period     out : last rise-to-rise period in cycles
//  high_width out : rise-to-fall width within that period
//  meas_valid out : one-cycle strobe, period/high_width updated
//  tone_match out : last published metric within NOM_PER +/- TOL
//  silent     out : no valid measurement since reset or timeout
//  period_avg out : mean of last 4 periods (only with SOUND_METER_AVG_EN defined)
module sound_pulse_meter
    import sound_pulse_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_CNT = DEF_MAX_CNT,
    parameter int NOM_PER = DEF_NOM_PER,
    parameter int TOL     = DEF_TOL
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_width,
    output logic             meas_valid,
    output logic             tone_match,
    output logic             silent
`ifdef SOUND_METER_AVG_EN
    ,
    output logic [CNT_W-1:0] period_avg
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // One extra bit so NOM_PER+TOL cannot overflow the compare.
    localparam logic [CNT_W:0]   TONE_LO  = (CNT_W+1)'(NOM_PER - TOL);
    localparam logic [CNT_W:0]   TONE_HI  = (CNT_W+1)'(NOM_PER + TOL);

    logic pin_level_unused;  // level is for other users of the detector
    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk_50M (clk_50M),
        .reset   (reset),
        .din     (pulse_in),
        .level   (pin_level_unused),
        .rise    (rise),
        .fall    (fall)
    );

    meter_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_w_tmp, high_w_tmp_nxt;
    logic             publish;
    logic             abort;
    logic [CNT_W-1:0] metric;
    logic             in_window;

`ifdef SOUND_METER_AVG_EN
    logic [CNT_W-1:0] hist [3];
    logic [CNT_W+1:0] hist_sum;
    logic [CNT_W-1:0] avg_nxt;

    // Average includes the period being published this cycle.
    assign hist_sum = (CNT_W+2)'(hist[0]) + (CNT_W+2)'(hist[1])
                    + (CNT_W+2)'(hist[2]) + (CNT_W+2)'(cnt);
    assign avg_nxt  = hist_sum[CNT_W+1:2];
    assign metric   = avg_nxt;
`else
    assign metric   = cnt;
`endif

    assign in_window = ({1'b0, metric} >= TONE_LO) && ({1'b0, metric} <= TONE_HI);

    // A rise coinciding with cnt==MAX_CNT restarts the measurement but
    // discards the overlong period (abort), so rise has priority over timeout.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        high_w_tmp_nxt = high_w_tmp;
        publish        = 1'b0;
        abort          = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (cnt == CNT_MAX) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (fall) begin
                        state_nxt      = ST_LOW;
                        high_w_tmp_nxt = cnt;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                    if (cnt == CNT_MAX) abort   = 1'b1;
                    else                publish = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            high_w_tmp <= '0;
            period     <= '0;
            high_width <= '0;
            meas_valid <= 1'b0;
            tone_match <= 1'b0;
            silent     <= 1'b1;
`ifdef SOUND_METER_AVG_EN
            hist[0]    <= '0;
            hist[1]    <= '0;
            hist[2]    <= '0;
            period_avg <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            high_w_tmp <= high_w_tmp_nxt;
            meas_valid <= publish;
            if (publish) begin
                period     <= cnt;
                high_width <= high_w_tmp;
                silent     <= 1'b0;
                tone_match <= in_window;
`ifdef SOUND_METER_AVG_EN
                hist[0]    <= cnt;
                hist[1]    <= hist[0];
                hist[2]    <= hist[1];
                period_avg <= avg_nxt;
`endif
            end
            if (abort) begin
                silent     <= 1'b1;
                tone_match <= 1'b0;
`ifdef SOUND_METER_AVG_EN
                hist[0]    <= '0;
                hist[1]    <= '0;
                hist[2]    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sound_pulse_meter.sv
// Purpose: self-checking bench for sound_pulse_meter with a strobe-driven scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sound_pulse_meter;

    localparam int CNT_W   = 10;
    localparam int MAX_CNT = 1023;
    localparam int NOM_PER = 500;
    localparam int TOL     = 5;

    logic             clk_50M = 1'b0;
    logic             reset   = 1'b1;
    logic             pulse_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_width;
    logic             meas_valid;
    logic             tone_match;
    logic             silent;
`ifdef SOUND_METER_AVG_EN
    logic [CNT_W-1:0] period_avg;
`endif

    sound_pulse_meter #(
        .CNT_W   (CNT_W),
        .MAX_CNT (MAX_CNT),
        .NOM_PER (NOM_PER),
        .TOL     (TOL)
    ) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .period     (period),
        .high_width (high_width),
        .meas_valid (meas_valid),
        .tone_match (tone_match),
        .silent     (silent)
`ifdef SOUND_METER_AVG_EN
        ,
        .period_avg (period_avg)
`endif
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int per;
        int hw;
        int tm;
        int avg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   have_prev = 1'b0;
    int   prev_per  = 0;
    int   prev_hw   = 0;
    int   hist [3]  = '{0, 0, 0};
    int   last_rise_cyc = 0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int in_win(input int m);
        return ((m >= NOM_PER - TOL) && (m <= NOM_PER + TOL)) ? 1 : 0;
    endfunction

    task automatic push_exp(input int per, input int hw);
        exp_t e;
        e.per = per;
        e.hw  = hw;
`ifdef SOUND_METER_AVG_EN
        e.avg   = (hist[0] + hist[1] + hist[2] + per) >> 2;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = per;
        e.tm    = in_win(e.avg);
`else
        e.avg = 0;
        e.tm  = in_win(per);
`endif
        sb.push_back(e);
    endtask

    // The DUT drops its partial measurement and history (timeout, discard, reset).
    task automatic forget();
        have_prev = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    // Rise now, high for h cycles, low for the rest of p cycles.
    task automatic pulse_cycle(input int h, input int p);
        if (have_prev) push_exp(prev_per, prev_hw);
        last_rise_cyc = cyc;
        pulse_in = 1'b1;
        wait_cyc(h);
        pulse_in = 1'b0;
        wait_cyc(p - h);
        have_prev = 1'b1;
        prev_per  = p;
        prev_hw   = h;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_period"},     int'(period), 0);
        chk({tag, "_high_width"}, int'(high_width), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_tone_match"}, int'(tone_match), 0);
        chk({tag, "_silent"},     int'(silent), 1);
    endtask

    // Monitor: every strobe must match the oldest expected result.
    always @(negedge clk_50M) begin
        if (!reset && meas_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", int'(meas_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("period",          int'(period), e.per);
                chk("high_width",      int'(high_width), e.hw);
                chk("tone_match",      int'(tone_match), e.tm);
                chk("silent_at_strobe", int'(silent), 0);
`ifdef SOUND_METER_AVG_EN
                chk("period_avg",      int'(period_avg), e.avg);
`endif
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1;
        pulse_in = 1'b0;
        wait_cyc(5);
        check_reset_values("reset");
        reset = 1'b0;
        wait_cyc(5);

        // 1: nominal 1 kHz train (scaled); first rise gives no strobe.
        for (int i = 0; i < 5; i++) pulse_cycle(106, 500);
        chk("t1_drained", sb.size(), 0);

        // 2: tolerance boundaries.
        pulse_cycle(106, 510);
        pulse_cycle(106, 505);
        pulse_cycle(106, 494);
        pulse_cycle(106, 495);
        pulse_cycle(106, 500);
        chk("t2_drained", sb.size(), 0);

        // 3: train stops low; timeout exactly MAX_CNT counts after the FSM saw the rise.
        forget();
        seen = 1'b0;
        for (int i = 0; i < 2 * MAX_CNT; i++) begin
            @(negedge clk_50M);
            if (silent) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_timeout_seen", int'(seen), 1);
        chk("t3_timeout_latency", cyc - last_rise_cyc, MAX_CNT + 4);
        chk("t3_tone_match", int'(tone_match), 0);
        chk("t3_period_hold", int'(period), 495);
        chk("t3_hw_hold", int'(high_width), 106);
        wait_cyc(1);
        pulse_cycle(106, 500);
        chk("t3_silent_after_first_rise", int'(silent), 1);
        pulse_cycle(106, 500);
        chk("t3_silent_cleared", int'(silent), 0);
        chk("t3_drained", sb.size(), 0);

        // 4: rise lands on cnt==MAX_CNT -> discarded, next period measured from it.
        pulse_cycle(106, MAX_CNT);
        chk("t4_silent_before", int'(silent), 0);
        forget();
        pulse_cycle(106, 500);
        chk("t4_silent_discard", int'(silent), 1);
        chk("t4_tone_match_discard", int'(tone_match), 0);
        pulse_cycle(120, 500);
        chk("t4_silent_after", int'(silent), 0);
        chk("t4_drained", sb.size(), 0);

        // 5: one-cycle reset in the middle of HIGH.
        if (have_prev) push_exp(prev_per, prev_hw);
        pulse_in = 1'b1;
        wait_cyc(20);
        chk("t5_pre_reset_period", int'(period), 500);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_reset_values("t5");
        forget();
        wait_cyc(30);
        pulse_in = 1'b0;
        wait_cyc(200);
        chk("t5_no_restart", int'(silent), 1);
        pulse_cycle(100, 480);
        pulse_cycle(100, 480);
        pulse_cycle(100, 480);
        chk("t5_drained", sb.size(), 0);

`ifdef SOUND_METER_AVG_EN
        // 6: running average over cleared history.
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        forget();
        wait_cyc(5);
        pulse_cycle(100, 400);
        pulse_cycle(100, 480);
        pulse_cycle(100, 520);
        pulse_cycle(100, 600);
        pulse_cycle(100, 500);
        chk("t6_avg_final", int'(period_avg), 500);
        chk("t6_tone_match_final", int'(tone_match), 1);
        chk("t6_drained", sb.size(), 0);
`endif

        wait_cyc(10);
        chk("pending_expected", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
